lcd_msg_scheduler: RTL and testbench
====================================

// Module: lcd_msg_scheduler
// PURPOSE
//  Shares the 16-char LCD line-2 data bus between NREQ message sources (LEA encrypt, decrypt, key entry).
//  Round-robin arbitrates requests and latches the winner's 128-bit block into a line buffer.
//  Holds the block on the LCD driver's 16 byte inputs for DWELL_CYC cycles, then blanks for BLANK_CYC cycles.
//  Sits between the LEA datapath and the LCD line driver; it never touches the LCD pins.
// PARAMETERS
//  NREQ       3     number of requesters (2..4)
//  DWELL_CYC  2200  cycles a message is held (>= 2 LCD refresh loops of ~1094 cycles); min 2
//  BLANK_CYC  64    cycles of all-space line between messages; min 1
// PORTS
//  CLK        in   1         system clock, also LCD_E
//  RESETN     in   1         reset, asynchronous, active-high
//  REQ        in   NREQ      per-source request; held high until the matching ACK
//  REQ_DATA   in   NREQ*128  source i block at [i*128 +: 128]; byte [127:120] is the leftmost char
//  ACK        out  NREQ      one-hot, 1-cycle pulse: block i latched
//  LINE_DATA  out  128       char 1 at [127:120] .. char 16 at [7:0]; feeds LCD_inputDATA_2_1..16
//  SRC_ID     out  2         index of the source currently displayed
//  VALID      out  1         high while in SHOW
//  BUSY       out  1         high in SHOW or BLANK
// BEHAVIOUR
//  Reset: state IDLE; LINE_DATA=16x8'h20; ACK=0; SRC_ID=0; VALID=0; BUSY=0; cnt=0; rr_ptr=0.
//  Reset mid-SHOW or mid-BLANK: immediate return to reset values; the pending source is not ACKed.
//  FSM IDLE -> SHOW -> BLANK -> IDLE. All outputs are registered.
//  IDLE: if |REQ at an edge, on that edge sel = first set REQ searching rr_ptr, rr_ptr+1, .. (mod NREQ).
//   On the same edge: latch the block into LINE_DATA, ACK[sel]=1, SRC_ID=sel, VALID=1, BUSY=1,
//   rr_ptr=(sel+1)%NREQ, cnt=0, state SHOW. Latency from REQ high in IDLE to ACK: 1 edge.
//  SHOW: ACK=0; cnt++. At cnt==DWELL_CYC-1: cnt=0, LINE_DATA=spaces, VALID=0, state BLANK.
//  BLANK: cnt++. At cnt==BLANK_CYC-1: cnt=0, BUSY=0, state IDLE.
//  REQ rising during SHOW/BLANK: left pending, not ACKed; it is arbitrated at the next IDLE edge.
//  REQ dropped before ACK: request withdrawn with no error.
//  REQ_DATA is sampled only on the latch edge; later changes do not affect LINE_DATA.
//  A single source holding REQ continuously is served every DWELL_CYC+BLANK_CYC+1 cycles.
//  All NREQ requesting from reset: served in order 0,1,2,0,..; no source waits more than NREQ slots.
//  cnt is 16 bits wide and wraps only by the explicit clears; parameters above 65535 are illegal.
//  sel outside 0..NREQ-1 cannot occur; the default branch returns the FSM to IDLE.
// CONFIGURATION
//  HEX_VIEW_EN defined: the latched block is rendered as hex ASCII of its upper 64 bits.
//   Each nibble maps 0-9 -> 8'h30-39 and A-F -> 8'h41-46; char 1 = bits [127:124].
//   Conversion is registered on the latch edge, so latency is unchanged.
//  Not defined: bytes pass through raw; any byte <8'h20 or >8'h7E is replaced by '.' (8'h2E).
// STRUCTURE
//  Package lcd_pkg: SPACE8=8'h20, DOT8=8'h2E, state enum {IDLE, SHOW, BLANK}, LINE_W=128, CHARS=16.
//  Sub-module lcd_char_fmt (combinational): 128-bit block -> 128-bit display line.
//   Contains both the hex and sanitize paths, selected by the macro.
//  Top holds the FSM, counter, rr pointer and line register; the arbiter is inline.
// TESTING
//  1 REQ=3'b001, block "ENC.MESSAGE....." -> ACK=001 one edge later; LINE_DATA equal to the block;
//    VALID high for 2200 cycles; then 64 cycles of 16x8'h20; BUSY low after that.
//  2 REQ=3'b111 from reset -> ACK sequence 001,010,100,001; SRC_ID 0,1,2,0; each 2265 cycles apart.
//  3 REQ[1] raised at SHOW cycle 100 while source 0 is shown -> ACK[1] only after BLANK ends;
//    LINE_DATA unchanged until then.
//  4 RESETN pulsed at SHOW cycle 500 -> same cycle LINE_DATA=spaces, VALID=0, BUSY=0, no ACK;
//    REQ still high afterwards -> re-served with ACK.
//  5 Block bytes 8'h00,8'h7F,8'h41 -> line chars '.','.','A' (macro off).
//    With HEX_VIEW_EN, block 128'h0123456789ABCDEF_x -> "0123456789ABCDEF".
//  6 REQ[2] pulsed for 1 cycle while state is BLANK and dropped -> never ACKed; FSM returns to IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared constants, state encoding and helpers for the LCD line-2 message
// scheduler slice.
//   SPACE8 / DOT8 : blank and substitute characters
//   LINE_W / CHARS: line width in bits / characters
//   state_t       : FSM encoding (IDLE, SHOW, BLANK)
//   hex_ascii()   : nibble -> ASCII hex digit (used when HEX_VIEW_EN is defined)
// ----------------------------------------------------------------------------
package lcd_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned CHARS  = 16;

    localparam logic [7:0] SPACE8 = 8'h20;
    localparam logic [7:0] DOT8   = 8'h2E;

    localparam logic [LINE_W-1:0] SPACE_LINE = {CHARS{SPACE8}};

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHOW  = 2'd1;
    localparam state_t BLANK = 2'd2;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// ----------------------------------------------------------------------------
// lcd_msg_scheduler_if
// Request/line bus between the message sources, the scheduler and the LCD
// line driver.
//   REQ       : per-source request, held until the matching ACK
//   REQ_DATA  : source i block at [i*128 +: 128], leftmost char in [127:120]
//   ACK       : one-hot 1-cycle pulse, block latched
//   LINE_DATA : 16 characters for the driver, char 1 at [127:120]
//   SRC_ID    : index of the source being shown
//   VALID     : a message is being shown
//   BUSY      : showing or blanking
// Modports: master = source/driver side, slave = scheduler.
// ----------------------------------------------------------------------------
interface lcd_msg_scheduler_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]     REQ;
    logic [NREQ*128-1:0] REQ_DATA;
    logic [NREQ-1:0]     ACK;
    logic [127:0]        LINE_DATA;
    logic [1:0]          SRC_ID;
    logic                VALID;
    logic                BUSY;

    modport master (
        output REQ, REQ_DATA,
        input  ACK, LINE_DATA, SRC_ID, VALID, BUSY
    );

    modport slave (
        input  REQ, REQ_DATA,
        output ACK, LINE_DATA, SRC_ID, VALID, BUSY
    );
endinterface

// File: rtl/lcd_char_fmt.sv
// ----------------------------------------------------------------------------
// lcd_char_fmt
// Combinational conversion of a 128-bit message block into a 16-character
// display line.
//   i_block : raw block, byte [127:120] is the leftmost character
//   o_line  : display line, char 1 at [127:120]
// Build option HEX_VIEW_EN: render the upper 64 bits as 16 hex digits.
// Default build: pass bytes through, replacing non-printables with '.'.
// ----------------------------------------------------------------------------
module lcd_char_fmt
    import lcd_pkg::*;
(
    input  logic [LINE_W-1:0] i_block,
    output logic [LINE_W-1:0] o_line
);

`ifdef HEX_VIEW_EN
    // Lower half of the block is not displayed in hex mode.
    logic unused_lo;
    assign unused_lo = ^i_block[63:0];

    always_comb begin
        o_line = SPACE_LINE;
        // Character slot c (c=15 is char 1) shows nibble [64+4c +: 4].
        for (int c = 0; c < int'(CHARS); c++) begin
            o_line[c*8 +: 8] = hex_ascii(i_block[64 + c*4 +: 4]);
        end
    end
`else
    always_comb begin
        o_line = SPACE_LINE;
        for (int c = 0; c < int'(CHARS); c++) begin
            if ((i_block[c*8 +: 8] < 8'h20) || (i_block[c*8 +: 8] > 8'h7E)) begin
                o_line[c*8 +: 8] = DOT8;
            end else begin
                o_line[c*8 +: 8] = i_block[c*8 +: 8];
            end
        end
    end
`endif

endmodule

// File: rtl/lcd_msg_scheduler.sv
// ----------------------------------------------------------------------------
// lcd_msg_scheduler
// Round-robin shares the LCD line-2 data bus between NREQ message sources.
// The winning block is formatted and latched, held for DWELL_CYC cycles, then
// the line is blanked for BLANK_CYC cycles before the next arbitration.
//   CLK    : system clock (also LCD_E)
//   RESETN : asynchronous reset, active high
//   bus    : lcd_msg_scheduler_if.slave (REQ, REQ_DATA, ACK, LINE_DATA,
//            SRC_ID, VALID, BUSY)
// Build option HEX_VIEW_EN selects hex rendering inside lcd_char_fmt.
// ----------------------------------------------------------------------------
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned DWELL_CYC = 2200,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic               CLK,
    input  logic               RESETN,
    lcd_msg_scheduler_if.slave bus
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYC - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [1:0]        r_rr_ptr;
    logic [LINE_W-1:0] r_line;
    logic [NREQ-1:0]   r_ack;
    logic [1:0]        r_src_id;
    logic              r_valid;
    logic              r_busy;

    logic              w_found;
    logic [1:0]        w_sel;
    logic [1:0]        w_rr_next;
    logic [NREQ-1:0]   w_onehot;
    logic [LINE_W-1:0] w_sel_block;
    logic [LINE_W-1:0] w_fmt_line;

    // Round-robin arbiter: search rr_ptr, rr_ptr+1, ... (mod NREQ).
    always_comb begin
        int t;
        t           = 0;
        w_found     = 1'b0;
        w_sel       = 2'd0;
        w_onehot    = '0;
        w_sel_block = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            t = int'(r_rr_ptr) + k;
            if (t >= int'(NREQ)) begin
                t = t - int'(NREQ);
            end
            for (int j = 0; j < int'(NREQ); j++) begin
                if (!w_found && (j == t) && bus.REQ[j]) begin
                    w_found     = 1'b1;
                    w_sel       = 2'(j);
                    w_onehot[j] = 1'b1;
                    w_sel_block = bus.REQ_DATA[j*LINE_W +: LINE_W];
                end
            end
        end
        w_rr_next = (int'(w_sel) == int'(NREQ) - 1) ? 2'd0 : w_sel + 2'd1;
    end

    lcd_char_fmt u_fmt (
        .i_block (w_sel_block),
        .o_line  (w_fmt_line)
    );

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            r_state  <= IDLE;
            r_cnt    <= 16'd0;
            r_rr_ptr <= 2'd0;
            r_line   <= SPACE_LINE;
            r_ack    <= '0;
            r_src_id <= 2'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_line   <= w_fmt_line;
                        r_ack    <= w_onehot;
                        r_src_id <= w_sel;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_rr_ptr <= w_rr_next;
                        r_cnt    <= 16'd0;
                        r_state  <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_cnt == DWELL_LAST) begin
                        r_cnt   <= 16'd0;
                        r_line  <= SPACE_LINE;
                        r_valid <= 1'b0;
                        r_state <= BLANK;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt   <= 16'd0;
                    r_line  <= SPACE_LINE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ACK       = r_ack;
    assign bus.LINE_DATA = r_line;
    assign bus.SRC_ID    = r_src_id;
    assign bus.VALID     = r_valid;
    assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lcd_msg_scheduler
// Directed bench for lcd_msg_scheduler. Expected ACK/SRC_ID/LINE_DATA tuples
// are queued as requests are issued; a monitor pops one per observed ACK.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_msg_scheduler;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned DWELL  = 2200;
    localparam int unsigned BLANK  = 64;
    localparam int          PERIOD = DWELL + BLANK + 1;
    localparam logic [127:0] SPACES = {16{8'h20}};

    typedef struct packed {
        logic [2:0]   ack;
        logic [1:0]   src;
        logic [127:0] line;
    } exp_t;

    logic CLK    = 1'b0;
    logic RESETN = 1'b1;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    lcd_msg_scheduler_if #(.NREQ(NREQ)) bus ();

    lcd_msg_scheduler #(
        .NREQ      (NREQ),
        .DWELL_CYC (DWELL),
        .BLANK_CYC (BLANK)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [2:0] ack, input logic [1:0] src, input logic [127:0] line);
        exp_t e;
        e.ack  = ack;
        e.src  = src;
        e.line = line;
        exp_q.push_back(e);
    endtask

    // Expected display line for a block whose bytes are all printable.
    function automatic logic [127:0] disp(input logic [127:0] b);
`ifdef HEX_VIEW_EN
        logic [127:0] r;
        logic [3:0]   nb;
        r = '0;
        for (int m = 0; m < 16; m++) begin
            nb = b[127-4*m -: 4];
            r[127-8*m -: 8] = (nb < 4'd10) ? (8'h30 + {4'h0, nb}) : (8'h41 + {4'h0, nb} - 8'd10);
        end
        return r;
`else
        return b;
`endif
    endfunction

    task automatic wait_ack(input string name, output int t);
        int n;
        n = 0;
        @(negedge CLK);
        while (bus.ACK === '0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        t = cyc;
        chk({name, "_seen"}, 128'(bus.ACK !== '0), 128'(1));
    endtask

    task automatic count_valid(output int n);
        n = 0;
        while (bus.VALID === 1'b1 && n < 10000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 10000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        count_busy(n);
        chk(name, 128'(bus.BUSY), 128'(0));
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.ACK !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 128'(bus.ACK), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ack", 128'(bus.ACK), 128'(e.ack));
                    chk("sb_src_id", 128'(bus.SRC_ID), 128'(e.src));
                    chk("sb_line", bus.LINE_DATA, e.line);
                    chk("sb_valid", 128'(bus.VALID), 128'(1));
                    chk("sb_busy", 128'(bus.BUSY), 128'(1));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk_a, blk_b, d0, d1, d2, raw5, exp5;
        int t0, t1, tp, n, bad, n_ack;

        bus.REQ      = '0;
        bus.REQ_DATA = '0;
        RESETN       = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset values
        chk("rst_line", bus.LINE_DATA, SPACES);
        chk("rst_ack", 128'(bus.ACK), 128'(0));
        chk("rst_src", 128'(bus.SRC_ID), 128'(0));
        chk("rst_valid", 128'(bus.VALID), 128'(0));
        chk("rst_busy", 128'(bus.BUSY), 128'(0));
        RESETN = 1'b0;
        @(negedge CLK);

        // T1: single request, show/blank timing
        blk_a = "ENC.MESSAGE.....";
        bus.REQ_DATA[127:0] = blk_a;
        bus.REQ = 3'b001;
        push_exp(3'b001, 2'd0, disp(blk_a));
        t0 = cyc;
        wait_ack("t1_ack", t1);
        chki("t1_latency", t1 - t0, 1);
        bus.REQ = '0;
        count_valid(n);
        chki("t1_show_len", n, DWELL);
        chk("t1_blank_line", bus.LINE_DATA, SPACES);
        chk("t1_blank_busy", 128'(bus.BUSY), 128'(1));
        count_busy(n);
        chki("t1_blank_len", n, BLANK);
        chk("t1_idle_valid", 128'(bus.VALID), 128'(0));

        // T5: byte sanitising (or hex view)
        raw5 = {8'h00, 8'h7F, 8'h41, 8'h1F, 8'h20, 8'h7E, 8'h80, 8'hFF, "abcdefgh"};
        exp5 = {8'h2E, 8'h2E, 8'h41, 8'h2E, 8'h20, 8'h7E, 8'h2E, 8'h2E, "abcdefgh"};
`ifdef HEX_VIEW_EN
        raw5 = 128'h0123456789ABCDEF_5A5A5A5A5A5A5A5A;
        exp5 = "0123456789ABCDEF";
`endif
        bus.REQ_DATA[255:128] = raw5;
        bus.REQ = 3'b010;
        push_exp(3'b010, 2'd1, exp5);
        wait_ack("t5_ack", t1);
        bus.REQ = '0;
        bus.REQ_DATA[255:128] = '0;
        wait_idle("t5_idle");

        // T2: all three requesting from reset
        @(negedge CLK);
        RESETN = 1'b1;
        d0 = "SRC0 ENCRYPT    ";
        d1 = "SRC1 DECRYPT    ";
        d2 = "SRC2 KEY ENTRY  ";
        bus.REQ_DATA = {d2, d1, d0};
        bus.REQ = 3'b111;
        push_exp(3'b001, 2'd0, disp(d0));
        push_exp(3'b010, 2'd1, disp(d1));
        push_exp(3'b100, 2'd2, disp(d2));
        push_exp(3'b001, 2'd0, disp(d0));
        @(negedge CLK);
        chk("t2_rst_src", 128'(bus.SRC_ID), 128'(0));
        chk("t2_rst_line", bus.LINE_DATA, SPACES);
        chk("t2_rst_ack", 128'(bus.ACK), 128'(0));
        t0 = cyc;
        tp = 0;
        RESETN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ack("t2_ack", t1);
            if (i == 0) chki("t2_latency", t1 - t0, 1);
            else chki("t2_gap", t1 - tp, PERIOD);
            tp = t1;
        end
        bus.REQ = '0;
        wait_idle("t2_idle");

        // T3: request raised mid-SHOW waits for the blank to finish
        blk_a = "ENC BLOCK 0000AA";
        blk_b = "DEC BLOCK 1111BB";
        bus.REQ_DATA = {d2, blk_b, blk_a};
        bus.REQ = 3'b001;
        push_exp(3'b001, 2'd0, disp(blk_a));
        wait_ack("t3_ack0", t0);
        bus.REQ = '0;
        repeat (100) @(negedge CLK);
        bus.REQ[1] = 1'b1;
        push_exp(3'b010, 2'd1, disp(blk_b));
        bad = 0;
        n = 0;
        while (bus.VALID === 1'b1 && n < 5000) begin
            if (bus.LINE_DATA !== disp(blk_a)) bad++;
            if (bus.ACK !== '0) bad++;
            n++;
            @(negedge CLK);
        end
        chki("t3_line_hold", bad, 0);
        wait_ack("t3_ack1", t1);
        chki("t3_gap", t1 - t0, PERIOD);

        // T4: reset mid-SHOW with REQ[1] still held
        repeat (500) @(negedge CLK);
        push_exp(3'b010, 2'd1, disp(blk_b));
        RESETN = 1'b1;
        #1;
        chk("t4_line", bus.LINE_DATA, SPACES);
        chk("t4_valid", 128'(bus.VALID), 128'(0));
        chk("t4_busy", 128'(bus.BUSY), 128'(0));
        chk("t4_ack", 128'(bus.ACK), 128'(0));
        @(negedge CLK);
        RESETN = 1'b0;
        t0 = cyc;
        wait_ack("t4_reserve", t1);
        chki("t4_latency", t1 - t0, 1);
        bus.REQ = '0;

        // T6: one-cycle REQ[2] pulse during BLANK is withdrawn
        count_valid(n);
        chk("t6_in_blank", 128'(bus.BUSY), 128'(1));
        repeat (10) @(negedge CLK);
        bus.REQ[2] = 1'b1;
        @(negedge CLK);
        bus.REQ[2] = 1'b0;
        n_ack = 0;
        repeat (200) begin
            @(negedge CLK);
            if (bus.ACK !== '0) n_ack++;
        end
        chki("t6_no_ack", n_ack, 0);
        chk("t6_idle_busy", 128'(bus.BUSY), 128'(0));
        chk("t6_idle_valid", 128'(bus.VALID), 128'(0));

        chki("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
